cpu_sequencer: RTL and testbench

- Multi-cycle control FSM for the simple_cpu core.
- It sequences instruction fetch, decode, execute, memory access and writeback around the existing datapath and the combinational control decoder.
- It owns the handshakes to the instruction and data memories, and generates every write-enable strobe: PC, IR, register file.
- It maintains a retired-instruction counter, and halts on SYSTEM, on an undecodable instruction, or on a memory timeout.

---
 rtl/cpu_sequencer_pkg.sv | 63 ++++++
 rtl/cpu_sequencer_seq_wait_timer.sv | 35 +++
 rtl/cpu_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the simple_cpu multi-cycle sequencer.
// Holds the FSM state codes, next-PC / writeback select codes, halt cause
// codes, the one-hot instruction-class bit positions and the fixed-priority
// class encoder used in DECODE.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [1:0] PC_SRC_SEQ  = 2'b00;  // PC+4
    localparam logic [1:0] PC_SRC_BR   = 2'b01;  // branch / JAL target
    localparam logic [1:0] PC_SRC_JALR = 2'b10;  // JALR target

    localparam logic [1:0] WB_SRC_ALU  = 2'b00;
    localparam logic [1:0] WB_SRC_MEM  = 2'b01;
    localparam logic [1:0] WB_SRC_PC4  = 2'b10;

    localparam logic [1:0] HALT_NONE    = 2'b00;
    localparam logic [1:0] HALT_SYSTEM  = 2'b01;
    localparam logic [1:0] HALT_ILLEGAL = 2'b10;
    localparam logic [1:0] HALT_BUSERR  = 2'b11;

    // One-hot class bit positions; a higher index has higher decode priority.
    localparam int CLS_W      = 10;
    localparam int CLS_ALUREG = 0;
    localparam int CLS_ALUIMM = 1;
    localparam int CLS_AUIPC  = 2;
    localparam int CLS_LUI    = 3;
    localparam int CLS_JALR   = 4;
    localparam int CLS_JAL    = 5;
    localparam int CLS_BRANCH = 6;
    localparam int CLS_STORE  = 7;
    localparam int CLS_LOAD   = 8;
    localparam int CLS_SYSTEM = 9;

    // Classes that finish through the register-file writeback state.
    localparam logic [CLS_W-1:0] WB_CLASSES =
        (CLS_W'(1) << CLS_JAL)   | (CLS_W'(1) << CLS_JALR)  |
        (CLS_W'(1) << CLS_LUI)   | (CLS_W'(1) << CLS_AUIPC) |
        (CLS_W'(1) << CLS_ALUIMM) | (CLS_W'(1) << CLS_ALUREG);

    // Reduce the raw decode flags (indexed by class position) to a single
    // one-hot class. Ascending scan lets the highest set index win.
    function automatic logic [CLS_W-1:0] class_onehot(input logic [CLS_W-1:0] flags);
        logic [CLS_W-1:0] oh;
        oh = '0;
        for (int i = 0; i < CLS_W; i++) begin
            if (flags[i]) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/cpu_sequencer_seq_wait_timer.sv
// Memory wait timer for the sequencer.
// Counts cycles spent waiting for a memory ready and flags when the count
// has reached TIMEOUT. The count saturates at TIMEOUT.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : return the count to zero (takes priority over en)
//   en        : count one more wait cycle
//   timeout   : count has reached TIMEOUT
module seq_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign timeout = (cnt_q == LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the simple_cpu core.
// Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB, drives
// the instruction/data memory handshakes and the PC, IR and register-file
// write strobes, counts retired instructions and halts on SYSTEM, on an
// undecodable instruction or on a memory wait timeout.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   ALUreg .. SYSTEM             : instruction-class flags from opcode decode
//   branch_taken                 : branch compare result, used in EXECUTE
//   imem_ready, dmem_ready       : memory handshake completions
//   imem_req, dmem_req, dmem_we  : memory requests
//   ir_we, rf_we, pc_we          : single-cycle write strobes
//   pc_src, wb_src               : next-PC and writeback selects
//   state, halted, halt_cause    : debug / status
//   instret                      : retired-instruction counter
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ALUreg,
    input  logic                 ALUimm,
    input  logic                 Branch,
    input  logic                 JAL,
    input  logic                 JALR,
    input  logic                 LUI,
    input  logic                 AUIPC,
    input  logic                 Load,
    input  logic                 Store,
    input  logic                 SYSTEM,
    input  logic                 branch_taken,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 ir_we,
    output logic                 rf_we,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic [1:0]           wb_src,
    output logic [2:0]           state,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic [CNT_WIDTH-1:0] instret
);

    state_t               state_q, state_d;
    logic [CLS_W-1:0]     cls_q, cls_d;
    logic [1:0]           cause_q, cause_d;
    logic [CNT_WIDTH-1:0] instret_q;

    logic [CLS_W-1:0] flags;
    logic             waiting;
    logic             ready_now;
    logic             timeout;

    assign flags = {SYSTEM, Load, Store, Branch, JAL, JALR, LUI, AUIPC, ALUimm, ALUreg};

    // A ready only counts inside the state that is waiting for it.
    assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign ready_now = ((state_q == S_FETCH) && imem_ready) ||
                       ((state_q == S_MEM)   && dmem_ready);

    // Clearing whenever we are outside a wait state gives a zero count on
    // entry to FETCH and MEM.
    seq_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!waiting || ready_now),
        .en      (waiting && !ready_now),
        .timeout (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cls_q     <= '0;
            cause_q   <= HALT_NONE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cause_q <= cause_d;
            if (pc_we) begin
                instret_q <= instret_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        cause_d  = cause_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = PC_SRC_SEQ;
        wb_src   = WB_SRC_ALU;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                // Ready beats a timeout reached in the same cycle; on a
                // genuine timeout the request is withdrawn immediately.
                if (imem_ready) begin
                    imem_req = 1'b1;
                    ir_we    = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    cause_d = HALT_BUSERR;
                    state_d = S_HALT;
                end else begin
                    imem_req = 1'b1;
                end
            end

            S_DECODE: begin
                cls_d = class_onehot(flags);
                if (flags == '0) begin
                    cause_d = HALT_ILLEGAL;
                    state_d = S_HALT;
                end else if (SYSTEM) begin
                    cause_d = HALT_SYSTEM;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                if (cls_q[CLS_LOAD] || cls_q[CLS_STORE]) begin
                    state_d = S_MEM;
                end else if (cls_q[CLS_BRANCH]) begin
                    pc_we   = 1'b1;
                    pc_src  = branch_taken ? PC_SRC_BR : PC_SRC_SEQ;
                    state_d = S_FETCH;
                end else if (|(cls_q & WB_CLASSES)) begin
                    state_d = S_WB;
                end else begin
                    // Unreachable for a correctly latched class; fail safe.
                    cause_d = HALT_ILLEGAL;
                    state_d = S_HALT;
                end
            end

            S_MEM: begin
                if (dmem_ready) begin
                    dmem_req = 1'b1;
                    dmem_we  = cls_q[CLS_STORE];
                    if (cls_q[CLS_STORE]) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    cause_d = HALT_BUSERR;
                    state_d = S_HALT;
                end else begin
                    dmem_req = 1'b1;
                    dmem_we  = cls_q[CLS_STORE];
                end
            end

            S_WB: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
                if (cls_q[CLS_LOAD]) begin
                    wb_src = WB_SRC_MEM;
                end else if (cls_q[CLS_JAL] || cls_q[CLS_JALR]) begin
                    wb_src = WB_SRC_PC4;
                end
                if (cls_q[CLS_JAL]) begin
                    pc_src = PC_SRC_BR;
                end else if (cls_q[CLS_JALR]) begin
                    pc_src = PC_SRC_JALR;
                end
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state      = state_q;
    assign halted     = (state_q == S_HALT);
    assign halt_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a directed table of instructions with hand-derived
// cycle counts and selects, hand-written wrap and mid-MEM reset sequences,
// and random instruction streams checked cycle by cycle against expected
// output traces generated per instruction from the sequencing rules.
module tb_cpu_sequencer;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [9:0] F_ALUREG = 10'd1;
    localparam logic [9:0] F_ALUIMM = 10'd2;
    localparam logic [9:0] F_LUI    = 10'd8;
    localparam logic [9:0] F_JALR   = 10'd16;
    localparam logic [9:0] F_JAL    = 10'd32;
    localparam logic [9:0] F_BR     = 10'd64;
    localparam logic [9:0] F_ST     = 10'd128;
    localparam logic [9:0] F_LD     = 10'd256;
    localparam logic [9:0] F_SYS    = 10'd512;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ALUreg = 0, ALUimm = 0, Branch = 0, JAL = 0, JALR = 0;
    logic LUI = 0, AUIPC = 0, Load = 0, Store = 0, SYSTEM = 0;
    logic branch_taken = 0, imem_ready = 0, dmem_ready = 0;
    logic imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, halted;
    logic [1:0] pc_src, wb_src, halt_cause;
    logic [2:0] state;
    logic [CW-1:0] instret;

    always #5 clk = ~clk;

    cpu_sequencer #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ALUreg(ALUreg), .ALUimm(ALUimm), .Branch(Branch), .JAL(JAL), .JALR(JALR),
        .LUI(LUI), .AUIPC(AUIPC), .Load(Load), .Store(Store), .SYSTEM(SYSTEM),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we),
        .pc_src(pc_src), .wb_src(wb_src), .state(state),
        .halted(halted), .halt_cause(halt_cause), .instret(instret)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       ireq, dreq, dwe, irw, rfw, pcw;
        logic [1:0] ps, ws;
        logic       hlt;
        logic [1:0] cause;
        logic [3:0] cnt;
    } obs_t;

    typedef struct packed {
        logic imr, dmr, bt;
        obs_t exp;
    } ent_t;

    typedef struct {
        logic [9:0] f;
        logic       bt;
        int         fw, mw;
        int         cyc;
        logic       rf;
        logic [1:0] ps, ws, cause;
    } dir_t;

    obs_t act;
    assign act = {state, imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we,
                  pc_src, wb_src, halted, halt_cause, instret};

    ent_t       q[$];
    logic [9:0] cur_flags = '0;
    int         m_cnt = 0;
    logic [1:0] m_cause = 2'd0;
    bit         m_halted = 0;
    int         nvec = 0, nbad = 0;
    int         ob_cyc;
    logic       ob_rf;
    logic [1:0] ob_ps, ob_ws;
    dir_t       tbl[14];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic obs_t mk(input logic [2:0] st, input logic ireq, dreq, dwe, irw, rfw, pcw,
                                input logic [1:0] ps, ws);
        obs_t o;
        o = {st, ireq, dreq, dwe, irw, rfw, pcw, ps, ws, (st == 3'd6), m_cause, 4'(m_cnt % 16)};
        return o;
    endfunction

    task automatic push(input logic imr, dmr, bt, input obs_t e);
        q.push_back({imr, dmr, bt, e});
    endtask

    task automatic go_halt(input logic [1:0] c);
        m_cause  = c;
        m_halted = 1;
        for (int i = 0; i < 3; i++) push(rb(), rb(), rb(), mk(3'd6, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    endtask

    task automatic apply_q();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            imem_ready   = e.imr;
            dmem_ready   = e.dmr;
            branch_taken = e.bt;
            {SYSTEM, Load, Store, Branch, JAL, JALR, LUI, AUIPC, ALUimm, ALUreg} = cur_flags;
            #1;
            check("trace", 32'(act), 32'(e.exp));
            if (state != 3'd0 && state != 3'd6) ob_cyc++;
            if (rf_we) begin ob_rf = 1'b1; ob_ws = wb_src; end
            if (pc_we) ob_ps = pc_src;
        end
    endtask

    // Expected trace of one instruction starting in FETCH: fw/mw are the
    // number of not-ready cycles before the memory answers.
    task automatic run_instr(input logic [9:0] f, input logic bt, input int fw, input int mw);
        int  cls;
        bit  st;
        logic [1:0] ps, ws;
        cur_flags = f;
        cls = -1;
        for (int i = 9; i >= 0; i--) if (f[i] && cls < 0) cls = i;
        if (fw > TO) begin
            for (int i = 0; i < TO; i++) push(0, rb(), rb(), mk(3'd1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0));
            push(0, rb(), rb(), mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
            go_halt(2'd3);
        end else begin
            for (int i = 0; i < fw; i++) push(0, rb(), rb(), mk(3'd1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0));
            push(1, rb(), rb(), mk(3'd1, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0));
            push(rb(), rb(), rb(), mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
            if (cls < 0) go_halt(2'd2);
            else if (cls == 9) go_halt(2'd1);
            else if (cls == 8 || cls == 7) begin
                st = (cls == 7);
                push(rb(), rb(), rb(), mk(3'd3, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
                if (mw > TO) begin
                    for (int i = 0; i < TO; i++) push(rb(), 0, rb(), mk(3'd4, 0, 1, st, 0, 0, 0, 2'd0, 2'd0));
                    push(rb(), 0, rb(), mk(3'd4, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
                    go_halt(2'd3);
                end else begin
                    for (int i = 0; i < mw; i++) push(rb(), 0, rb(), mk(3'd4, 0, 1, st, 0, 0, 0, 2'd0, 2'd0));
                    if (st) begin
                        push(rb(), 1, rb(), mk(3'd4, 0, 1, 1, 0, 0, 1, 2'd0, 2'd0));
                        m_cnt++;
                    end else begin
                        push(rb(), 1, rb(), mk(3'd4, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0));
                        push(rb(), rb(), rb(), mk(3'd5, 0, 0, 0, 0, 1, 1, 2'd0, 2'd1));
                        m_cnt++;
                    end
                end
            end else if (cls == 6) begin
                push(rb(), rb(), bt, mk(3'd3, 0, 0, 0, 0, 0, 1, bt ? 2'd1 : 2'd0, 2'd0));
                m_cnt++;
            end else begin
                ws = (cls == 5 || cls == 4) ? 2'd2 : 2'd0;
                ps = (cls == 5) ? 2'd1 : (cls == 4) ? 2'd2 : 2'd0;
                push(rb(), rb(), rb(), mk(3'd3, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
                push(rb(), rb(), rb(), mk(3'd5, 0, 0, 0, 0, 1, 1, ps, ws));
                m_cnt++;
            end
        end
        apply_q();
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2 rst = 1'b0;
        m_cnt = 0; m_cause = 2'd0; m_halted = 0;
        cur_flags = '0;
        push(rb(), rb(), rb(), mk(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
        apply_q();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        #1 check("reset_outputs", 32'(act), 32'd0);
        release_rst();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             flags        bt  fw mw cyc rf ps    ws    cause
        tbl[0]  = '{F_ALUREG,      0,  0, 0, 4, 1, 2'd0, 2'd0, 2'd0};
        tbl[1]  = '{F_LD,          0,  0, 3, 8, 1, 2'd0, 2'd1, 2'd0};
        tbl[2]  = '{F_BR,          1,  0, 0, 3, 0, 2'd1, 2'd3, 2'd0};
        tbl[3]  = '{F_BR,          0,  0, 0, 3, 0, 2'd0, 2'd3, 2'd0};
        tbl[4]  = '{F_JALR,        0,  0, 0, 4, 1, 2'd2, 2'd2, 2'd0};
        tbl[5]  = '{F_JAL,         0,  2, 0, 6, 1, 2'd1, 2'd2, 2'd0};
        tbl[6]  = '{F_LD | F_ST,   0,  0, 0, 5, 1, 2'd0, 2'd1, 2'd0};
        tbl[7]  = '{F_ST,          0,  0, 1, 5, 0, 2'd0, 2'd3, 2'd0};
        tbl[8]  = '{F_LUI|F_ALUREG,0,  0, 0, 4, 1, 2'd0, 2'd0, 2'd0};
        tbl[9]  = '{F_ALUIMM,      0,  4, 0, 8, 1, 2'd0, 2'd0, 2'd0};
        tbl[10] = '{10'd0,         0,  0, 0, 2, 0, 2'd3, 2'd3, 2'd2};
        tbl[11] = '{F_SYS | F_LD,  0,  0, 0, 2, 0, 2'd3, 2'd3, 2'd1};
        tbl[12] = '{F_ALUREG,      0,  5, 0, 5, 0, 2'd3, 2'd3, 2'd3};
        tbl[13] = '{F_LD,          0,  0, 5, 8, 0, 2'd3, 2'd3, 2'd3};

        reset_dut();
        for (int i = 0; i < 14; i++) begin
            if (m_halted) reset_dut();
            ob_cyc = 0; ob_rf = 1'b0; ob_ps = 2'd3; ob_ws = 2'd3;
            run_instr(tbl[i].f, tbl[i].bt, tbl[i].fw, tbl[i].mw);
            check($sformatf("dir%0d_cycles", i), 32'(ob_cyc), 32'(tbl[i].cyc));
            check($sformatf("dir%0d_rf_we", i), 32'(ob_rf), 32'(tbl[i].rf));
            check($sformatf("dir%0d_pc_src", i), 32'(ob_ps), 32'(tbl[i].ps));
            check($sformatf("dir%0d_wb_src", i), 32'(ob_ws), 32'(tbl[i].ws));
            check($sformatf("dir%0d_cause", i), 32'(halt_cause), 32'(tbl[i].cause));
        end

        // instret wraps: 17 retirements on a 4-bit counter leave 1.
        reset_dut();
        for (int i = 0; i < 17; i++) run_instr(F_ALUREG, 0, 0, 0);
        @(negedge clk);
        imem_ready = 1'b0;
        #1 check("instret_wrap", 32'(instret), 32'd1);

        // Reset asserted in the middle of a MEM wait.
        reset_dut();
        run_instr(F_ALUREG, 0, 0, 0);
        cur_flags = F_LD;
        {SYSTEM, Load, Store, Branch, JAL, JALR, LUI, AUIPC, ALUimm, ALUreg} = cur_flags;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            imem_ready = 1'b1;
            dmem_ready = 1'b0;
            #1;
            if (state == 3'd4) break;
        end
        check("reach_mem", 32'(state), 32'd4);
        #2 rst = 1'b1;
        #1 check("rst_mid_mem", 32'(act), 32'd0);
        release_rst();

        // Random instruction stream.
        reset_dut();
        for (int n = 0; n < 150; n++) begin
            logic [9:0] f;
            int k, fw, mw;
            if (m_halted) reset_dut();
            k = $urandom_range(0, 24);
            if (k == 0) f = '0;
            else if (k == 1) f = F_SYS | 10'($urandom);
            else begin
                k = $urandom_range(0, 8);
                f = (10'd1 << k) | (10'($urandom) & ((10'd1 << k) - 10'd1));
            end
            fw = ($urandom_range(0, 30) == 0) ? TO + 1 : $urandom_range(0, TO);
            mw = ($urandom_range(0, 20) == 0) ? TO + 1 : $urandom_range(0, TO);
            run_instr(f, rb(), fw, mw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
